// File: rtl/clk_div_rst_gen_if.sv
// Configuration bus for clk_div_rst_gen: single outstanding req/ack access.
// Latency: ack follows the accepted request by one cycle.
// Backpressure: requester holds req until ack, then drops it for a cycle.
// Ports: cfg_req_i/cfg_wrn_i/cfg_add_i/cfg_data_i from master; cfg_ack_o/cfg_r_data_o from slave.
interface clk_div_rst_gen_if #(
   parameter int ADDR_W = 2,
   parameter int DIV_W  = 8
) ();
   logic              cfg_req_i;
   logic              cfg_wrn_i;
   logic [ADDR_W-1:0] cfg_add_i;
   logic [DIV_W-1:0]  cfg_data_i;
   logic              cfg_ack_o;
   logic [DIV_W-1:0]  cfg_r_data_o;

   modport master (
      output cfg_req_i, cfg_wrn_i, cfg_add_i, cfg_data_i,
      input  cfg_ack_o, cfg_r_data_o
   );

   modport slave (
      input  cfg_req_i, cfg_wrn_i, cfg_add_i, cfg_data_i,
      output cfg_ack_o, cfg_r_data_o
   );
endinterface

// File: rtl/clk_div_rst_gen.sv
// Per-channel programmable clock divider with glitch-free divisor switching and synchronised resets.
// Latency: cfg ack one cycle after request; divisor takes effect at the next period boundary.
// Backpressure: one access per req pulse; req must drop for a cycle after ack before the next access.
// Ports: clk_i/rstn_i source clock and async active-low reset; testmode_i bypasses clocks and resets;
//        cfg (slave) divisor read/write bus; clk_o/rstn_o per-channel divided clock and reset;
//        div_stable_o per-channel "active divisor equals programmed divisor".
module clk_div_rst_gen #(
   parameter int NUM_CH      = 4,
   parameter int DIV_W       = 8,
   parameter int DIV_RST     = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic                testmode_i,
   clk_div_rst_gen_if.slave    cfg,
   output logic [NUM_CH-1:0]   clk_o,
   output logic [NUM_CH-1:0]   rstn_o,
   output logic [NUM_CH-1:0]   div_stable_o
);

   localparam int ADDR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_RST);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ACK  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   // A programmed divisor of 0 behaves as 1 (bypass).
   function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
      return (d == '0) ? DIV_ONE : d;
   endfunction

   // ---------------------------------------------------------------
   // Configuration handshake
   // ---------------------------------------------------------------
   logic [1:0]        st_q;
   logic              ack_q;
   logic [DIV_W-1:0]  rdata_q;
   logic              start;
   logic [DIV_W-1:0]  rd_val;
   logic [NUM_CH-1:0] wr_hit;

   logic [DIV_W-1:0]  shadow_q [NUM_CH];
   logic [DIV_W-1:0]  active_q [NUM_CH];
   logic [DIV_W-1:0]  cnt_q    [NUM_CH];
   logic [NUM_CH-1:0] clk_q;
   logic [NUM_CH-1:0] stable_q;
   logic [1:0]        rel_q    [NUM_CH];

   assign start = (st_q == ST_IDLE) && cfg.cfg_req_i;

   // Out-of-range addresses match no channel: reads return 0, writes are dropped.
   always_comb begin
      rd_val = '0;
      wr_hit = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (cfg.cfg_add_i == ADDR_W'(k)) begin
            rd_val    = shadow_q[k];
            wr_hit[k] = start && !cfg.cfg_wrn_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         st_q    <= ST_IDLE;
         ack_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         ack_q   <= start;
         rdata_q <= (start && cfg.cfg_wrn_i) ? rd_val : '0;
         case (st_q)
            ST_IDLE: if (cfg.cfg_req_i) st_q <= ST_ACK;
            // Request still high after ack: wait for it to drop before re-arming.
            ST_ACK:  st_q <= cfg.cfg_req_i ? ST_WAIT : ST_IDLE;
            ST_WAIT: if (!cfg.cfg_req_i) st_q <= ST_IDLE;
            default: st_q <= ST_IDLE;
         endcase
      end
   end

   assign cfg.cfg_ack_o    = ack_q;
   assign cfg.cfg_r_data_o = rdata_q;

   // ---------------------------------------------------------------
   // Reset synchroniser shared by all channels
   // ---------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rst_rel;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) sync_q <= '0;
      else         sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
   end

   assign rst_rel = sync_q[SYNC_STAGES-1];

   // ---------------------------------------------------------------
   // Divider channels
   // ---------------------------------------------------------------
   logic [DIV_W-1:0]  shd_d [NUM_CH];
   logic [DIV_W-1:0]  act_d [NUM_CH];
   logic [DIV_W-1:0]  cnt_d [NUM_CH];
   logic [NUM_CH-1:0] ld;
   logic [NUM_CH-1:0] byp;
   logic [NUM_CH-1:0] clk_d;
   logic [DIV_W-1:0]  d_cur;
   logic [DIV_W-1:0]  d_nxt;

   always_comb begin
      ld    = '0;
      byp   = '0;
      clk_d = '0;
      d_cur = '0;
      d_nxt = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         shd_d[k] = wr_hit[k] ? cfg.cfg_data_i : shadow_q[k];
         d_cur    = eff_div(active_q[k]);
         byp[k]   = (d_cur == DIV_ONE);
         // Switching only at the last count of a period keeps every pulse >= one clk_i cycle.
         ld[k]    = byp[k] || (cnt_q[k] == d_cur - DIV_ONE);
         act_d[k] = ld[k] ? shadow_q[k] : active_q[k];
         d_nxt    = eff_div(act_d[k]);
         cnt_d[k] = ld[k] ? '0 : cnt_q[k] + DIV_ONE;
         // Register tracks the count it will sit beside, so high spans cnt 0..D/2-1.
         clk_d[k] = (cnt_d[k] < (d_nxt >> 1));
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int k = 0; k < NUM_CH; k++) begin
            shadow_q[k] <= DIV_INIT;
            active_q[k] <= DIV_INIT;
            cnt_q[k]    <= '0;
            rel_q[k]    <= 2'd0;
         end
         clk_q    <= '0;
         stable_q <= '1;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            shadow_q[k] <= shd_d[k];
            active_q[k] <= act_d[k];
            cnt_q[k]    <= cnt_d[k];
            stable_q[k] <= (act_d[k] == shd_d[k]);
            // Count two period boundaries after the synchroniser releases; saturates,
            // so later divisor changes never pull the channel reset back down.
            if (rst_rel && ld[k] && (rel_q[k] != 2'd2))
               rel_q[k] <= rel_q[k] + 2'd1;
         end
         clk_q <= clk_d;
      end
   end

   always_comb begin
      clk_o  = '0;
      rstn_o = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (testmode_i) begin
            clk_o[k]  = clk_i;
            rstn_o[k] = rstn_i;
         end else begin
            clk_o[k]  = byp[k] ? clk_i : clk_q[k];
            rstn_o[k] = (rel_q[k] == 2'd2);
         end
      end
   end

   assign div_stable_o = stable_q;

endmodule

// File: tb/tb_clk_div_rst_gen.sv
// Directed bench for clk_div_rst_gen with five channels (so address 5 is out of range).
// Latency: n/a.
// Backpressure: n/a.
module tb_clk_div_rst_gen;
   localparam int NUM_CH = 5;
   localparam int DIV_W  = 8;
   localparam int ADDR_W = 3;

   logic              clk_i;
   logic              rstn_i;
   logic              testmode_i;
   logic [NUM_CH-1:0] clk_o;
   logic [NUM_CH-1:0] rstn_o;
   logic [NUM_CH-1:0] div_stable_o;

   int n_chk = 0;
   int n_err = 0;

   clk_div_rst_gen_if #(.ADDR_W(ADDR_W), .DIV_W(DIV_W)) cfg_bus ();

   clk_div_rst_gen #(
      .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DIV_RST(1), .SYNC_STAGES(2)
   ) dut (
      .clk_i(clk_i),
      .rstn_i(rstn_i),
      .testmode_i(testmode_i),
      .cfg(cfg_bus),
      .clk_o(clk_o),
      .rstn_o(rstn_o),
      .div_stable_o(div_stable_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Sample point in the clk_i-high phase.
   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   // Sample point in the clk_i-low phase.
   task automatic tick_lo();
      @(negedge clk_i);
      #2;
   endtask

   // One cycle with req low first, so the handshake is re-armed; lat = -1 on timeout.
   task automatic bus_access(input logic wrn, input logic [ADDR_W-1:0] addr,
                             input logic [DIV_W-1:0] data,
                             output int lat, output logic [DIV_W-1:0] rdat);
      tick();
      cfg_bus.cfg_req_i  = 1'b1;
      cfg_bus.cfg_wrn_i  = wrn;
      cfg_bus.cfg_add_i  = addr;
      cfg_bus.cfg_data_i = data;
      lat  = -1;
      rdat = '0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         if (cfg_bus.cfg_ack_o) begin
            lat  = i;
            rdat = cfg_bus.cfg_r_data_o;
            break;
         end
      end
      cfg_bus.cfg_req_i = 1'b0;
   endtask

   int               lat;
   logic [DIV_W-1:0] rd;
   logic [15:0]      pat;
   int               acks;
   logic [DIV_W-1:0] exp_sh [NUM_CH];

   initial begin
      rstn_i             = 1'b0;
      testmode_i         = 1'b0;
      cfg_bus.cfg_req_i  = 1'b0;
      cfg_bus.cfg_wrn_i  = 1'b0;
      cfg_bus.cfg_add_i  = '0;
      cfg_bus.cfg_data_i = '0;

      // Reset state
      tick();
      tick();
      chk("rst_rstn_o", 32'(rstn_o), 32'h00);
      chk("rst_ack", 32'(cfg_bus.cfg_ack_o), 32'h0);
      chk("rst_rdata", 32'(cfg_bus.cfg_r_data_o), 32'h0);
      chk("rst_stable", 32'(div_stable_o), 32'h1F);
      chk("rst_clk_hi", 32'(clk_o), 32'h1F);
      tick_lo();
      chk("rst_clk_lo", 32'(clk_o), 32'h00);

      // Release: 2 synchroniser edges + 2 bypass periods
      tick();
      rstn_i = 1'b1;
      tick(); tick(); tick();
      chk("rel_rstn_early", 32'(rstn_o), 32'h00);
      tick();
      chk("rel_rstn_done", 32'(rstn_o), 32'h1F);
      chk("rel_clk_hi", 32'(clk_o), 32'h1F);
      chk("rel_stable", 32'(div_stable_o), 32'h1F);
      tick_lo();
      chk("rel_clk_lo", 32'(clk_o), 32'h00);

      // ch1 = 4: stable low until the switch, then 2 high / 2 low, both phases
      bus_access(1'b0, 3'd1, 8'd4, lat, rd);
      chk("w1_lat", 32'(lat), 32'd1);
      chk("w1_stable_pre", 32'(div_stable_o[1]), 32'h0);
      pat = '0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (i == 0) chk("w1_stable_post", 32'(div_stable_o[1]), 32'h1);
         pat = {pat[14:0], clk_o[1]};
         tick_lo();
         pat = {pat[14:0], clk_o[1]};
      end
      chk("w1_clk_pattern", 32'(pat), 32'hF0F0);
      chk("w1_rstn_kept", 32'(rstn_o), 32'h1F);

      // ch2 = 5, then 3 mid-period: no switch before cnt==4, then 1 high / 2 low
      bus_access(1'b0, 3'd2, 8'd5, lat, rd);
      chk("w2a_lat", 32'(lat), 32'd1);
      tick();
      chk("w2a_clk_cnt0", 32'(clk_o[2]), 32'h1);
      bus_access(1'b0, 3'd2, 8'd3, lat, rd);
      chk("w2b_lat", 32'(lat), 32'd1);
      chk("w2b_clk_cnt2", 32'(clk_o[2]), 32'h0);
      chk("w2b_stable_pre", 32'(div_stable_o[2]), 32'h0);
      pat = '0;
      for (int i = 0; i < 6; i++) begin
         tick();
         pat = {pat[14:0], clk_o[2]};
         if (i == 1) chk("w2b_stable_cnt4", 32'(div_stable_o[2]), 32'h0);
         if (i == 2) chk("w2b_stable_sw", 32'(div_stable_o[2]), 32'h1);
      end
      chk("w2b_clk_pattern", 32'(pat), 32'h09);
      chk("w2b_rstn_kept", 32'(rstn_o), 32'h1F);

      // Read-back and out-of-range address
      bus_access(1'b0, 3'd3, 8'h2A, lat, rd);
      chk("w3_lat", 32'(lat), 32'd1);
      bus_access(1'b1, 3'd3, 8'h00, lat, rd);
      chk("r3_lat", 32'(lat), 32'd1);
      chk("r3_data", 32'(rd), 32'h2A);
      tick();
      chk("r3_data_noack", 32'(cfg_bus.cfg_r_data_o), 32'h0);
      chk("r3_ack_single", 32'(cfg_bus.cfg_ack_o), 32'h0);
      bus_access(1'b1, 3'd5, 8'h00, lat, rd);
      chk("r5_lat", 32'(lat), 32'd1);
      chk("r5_data", 32'(rd), 32'h0);
      bus_access(1'b0, 3'd5, 8'h77, lat, rd);
      chk("w5_lat", 32'(lat), 32'd1);
      exp_sh[0] = 8'd1; exp_sh[1] = 8'd4; exp_sh[2] = 8'd3;
      exp_sh[3] = 8'h2A; exp_sh[4] = 8'd1;
      for (int k = 0; k < NUM_CH; k++) begin
         bus_access(1'b1, ADDR_W'(k), 8'h00, lat, rd);
         chk($sformatf("rb_ch%0d", k), 32'(rd), 32'(exp_sh[k]));
      end
      bus_access(1'b1, 3'd7, 8'h00, lat, rd);
      chk("r7_data", 32'(rd), 32'h0);
      chk("r7_lat", 32'(lat), 32'd1);

      // Divisor 0 behaves as bypass
      bus_access(1'b0, 3'd1, 8'd0, lat, rd);
      repeat (6) tick();
      chk("d0_clk_hi", 32'(clk_o[1]), 32'h1);
      chk("d0_stable", 32'(div_stable_o[1]), 32'h1);
      tick_lo();
      chk("d0_clk_lo", 32'(clk_o[1]), 32'h0);

      // Request held high for 5 cycles: one ack, one write
      tick();
      cfg_bus.cfg_req_i  = 1'b1;
      cfg_bus.cfg_wrn_i  = 1'b0;
      cfg_bus.cfg_add_i  = 3'd4;
      cfg_bus.cfg_data_i = 8'h55;
      acks = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (cfg_bus.cfg_ack_o) acks++;
         cfg_bus.cfg_data_i = 8'h66;
      end
      cfg_bus.cfg_req_i = 1'b0;
      tick();
      if (cfg_bus.cfg_ack_o) acks++;
      chk("hold_acks", 32'(acks), 32'd1);
      bus_access(1'b1, 3'd4, 8'h00, lat, rd);
      chk("hold_data", 32'(rd), 32'h55);

      // Test mode: clocks and resets follow the source combinationally
      bus_access(1'b0, 3'd0, 8'd6, lat, rd);
      repeat (8) tick();
      testmode_i = 1'b1;
      #1;
      chk("tm_clk_hi", 32'(clk_o), 32'h1F);
      tick_lo();
      chk("tm_clk_lo", 32'(clk_o), 32'h00);
      rstn_i = 1'b0;
      #1;
      chk("tm_rstn_low", 32'(rstn_o), 32'h00);
      rstn_i = 1'b1;
      #1;
      chk("tm_rstn_high", 32'(rstn_o), 32'h1F);
      testmode_i = 1'b0;
      #1;
      chk("tm_off_rstn", 32'(rstn_o), 32'h00);
      repeat (4) tick();
      chk("tm_rel_rstn", 32'(rstn_o), 32'h1F);

      // Reset in the middle of a read: no ack, outputs at reset values
      bus_access(1'b0, 3'd2, 8'd9, lat, rd);
      tick();
      cfg_bus.cfg_req_i = 1'b1;
      cfg_bus.cfg_wrn_i = 1'b1;
      cfg_bus.cfg_add_i = 3'd2;
      #3;
      rstn_i = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("mid_ack", 32'(cfg_bus.cfg_ack_o), 32'h0);
         chk("mid_rdata", 32'(cfg_bus.cfg_r_data_o), 32'h0);
      end
      chk("mid_rstn", 32'(rstn_o), 32'h00);
      chk("mid_stable", 32'(div_stable_o), 32'h1F);
      chk("mid_clk_hi", 32'(clk_o), 32'h1F);
      cfg_bus.cfg_req_i = 1'b0;
      rstn_i = 1'b1;
      repeat (4) tick();
      chk("post_rstn", 32'(rstn_o), 32'h1F);
      bus_access(1'b1, 3'd2, 8'h00, lat, rd);
      chk("post_lat", 32'(lat), 32'd1);
      chk("post_ch2", 32'(rd), 32'h1);
      bus_access(1'b1, 3'd0, 8'h00, lat, rd);
      chk("post_ch0", 32'(rd), 32'h1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
